// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: the write-back stage has priority over a small in-order
// buffer of multi-cycle results; the buffer head is forced through when full or starved.
module wb_port_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wb_rd,
  input  logic        wb_we,
  input  logic [31:0] wb_data,
  output logic        wb_stall,
  input  logic        mc_valid,
  output logic        mc_ready,
  input  logic [4:0]  mc_rd,
  input  logic [31:0] mc_data,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] pending_mask
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]            q_rd   [FIFO_DEPTH];
  logic [31:0]           q_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] q_valid;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic [SW-1:0]         starve_cnt;

  logic full, cand_p, cand_f, grant_f, grant_p, push, pop;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign cand_p   = wb_we && (wb_rd != 5'd0);
  assign cand_f   = (count != '0);
  // Grants are suppressed during reset so nothing is popped or written mid-reset.
  assign grant_f  = !rst && cand_f &&
                    (!cand_p || full || (starve_cnt == SW'(STARVE_LIMIT)));
  assign grant_p  = !rst && cand_p && !grant_f;
  assign wb_stall = cand_p && grant_f;
  assign mc_ready = !rst && !full;
  // Results targeting x0 are acknowledged but never buffered.
  assign push     = mc_valid && mc_ready && (mc_rd != 5'd0);
  assign pop      = grant_f;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      q_valid    <= '0;
      starve_cnt <= '0;
    end else begin
      if (push) begin
        q_valid[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        q_valid[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (grant_f || !cand_f)
        starve_cnt <= '0;
      else if (grant_p && (starve_cnt != SW'(STARVE_LIMIT)))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= mc_rd;
      q_data[wr_ptr] <= mc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= grant_f || grant_p;
      if (grant_f) begin
        rf_waddr <= q_rd[rd_ptr];
        rf_wdata <= q_data[rd_ptr];
      end else if (grant_p) begin
        rf_waddr <= wb_rd;
        rf_wdata <= wb_data;
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (q_valid[i]) pending_mask[q_rd[i]] = 1'b1;
    if (rf_we) pending_mask[rf_waddr] = 1'b1;
    pending_mask[0] = 1'b0;
    if (rst) pending_mask = '0;
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a queue-based reference model predicts grants and
// register-file writes; a separate monitor compares every rf write against the expected queue.
module tb_wb_port_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  wb_rd = '0;
  logic        wb_we = 1'b0;
  logic [31:0] wb_data = '0;
  logic        wb_stall;
  logic        mc_valid = 1'b0;
  logic        mc_ready;
  logic [4:0]  mc_rd = '0;
  logic [31:0] mc_data = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pending_mask;

  wb_port_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data), .wb_stall(wb_stall),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_rd(mc_rd), .mc_data(mc_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  int          total = 0;
  int          bad = 0;
  ent_t        mq[$];
  logic [36:0] exp_q[$];
  int          starve = 0;
  logic        last_we = 1'b0;
  logic [4:0]  last_addr = '0;
  logic [31:0] last_data = '0;
  bit          last_stall = 1'b0;
  int          stalls = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every rf write must match the oldest predicted write.
  always @(negedge clk) begin
    logic [36:0] e;
    if (rf_we === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rf_write: got x%0d=%0h expected no write at %0t", rf_waddr, rf_wdata, $time);
      end else begin
        e = exp_q.pop_front();
        if ({rf_waddr, rf_wdata} !== e) begin
          bad++;
          $display("FAIL rf_write: got x%0d=%0h expected x%0d=%0h at %0t",
                   rf_waddr, rf_wdata, e[36:32], e[31:0], $time);
        end
      end
    end
  end

  task automatic set_in(input logic we, input logic [4:0] rd, input logic [31:0] d,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    wb_we = we; wb_rd = rd; wb_data = d;
    mc_valid = mv; mc_rd = mrd; mc_data = md;
  endtask

  // One clock cycle: check outputs against the model, advance the model, then move past the edge.
  task automatic step();
    bit          p, f, gf, gp, rdy;
    logic [31:0] m;
    @(negedge clk);
    chk("rf_waddr_hold", rf_waddr, last_addr);
    chk("rf_wdata_hold", rf_wdata, last_data);
    if (rst) begin
      chk("rst_stall", wb_stall, 0);
      chk("rst_ready", mc_ready, 0);
      chk("rst_mask", pending_mask, 0);
      mq.delete();
      starve = 0; last_we = 0; last_addr = '0; last_data = '0; last_stall = 0;
    end else begin
      p   = wb_we && (wb_rd != 0);
      f   = mq.size() > 0;
      gf  = f && (!p || mq.size() == DEPTH || starve == LIMIT);
      gp  = p && !gf;
      rdy = mq.size() < DEPTH;
      m = '0;
      foreach (mq[i]) m[mq[i].rd] = 1'b1;
      if (last_we) m[last_addr] = 1'b1;
      m[0] = 1'b0;
      chk("wb_stall", wb_stall, p && gf);
      chk("mc_ready", mc_ready, rdy);
      chk("pending_mask", pending_mask, m);
      if (wb_stall === 1'b1) stalls++;
      if (gf) begin
        exp_q.push_back({mq[0].rd, mq[0].data});
        last_addr = mq[0].rd; last_data = mq[0].data;
        void'(mq.pop_front());
      end else if (gp) begin
        exp_q.push_back({wb_rd, wb_data});
        last_addr = wb_rd; last_data = wb_data;
      end
      last_we = gf || gp;
      last_stall = p && gf;
      if (mc_valid && rdy && mc_rd != 0) mq.push_back('{rd: mc_rd, data: mc_data});
      if (gf || !f) starve = 0;
      else if (gp) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    set_in(0, 0, 0, 0, 0, 0);
    repeat (n) step();
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    idle(1);

    // pipeline-only traffic, including a write to x0
    set_in(1, 5, 32'h1234, 0, 0, 0);  step();
    set_in(1, 0, 32'h9, 0, 0, 0);     step();
    idle(2);

    // idle-pipeline drain in order
    set_in(0, 0, 0, 1, 7, 32'hAA);    step();
    set_in(0, 0, 0, 1, 8, 32'hBB);    step();
    idle(4);

    // full FIFO forces the head through while the pipeline holds its request
    set_in(1, 9, 32'h99, 1, 10, 32'hA0); step();
    set_in(1, 9, 32'h99, 1, 11, 32'hA1); step();
    set_in(1, 9, 32'h99, 0, 0, 0);
    repeat (6) step();
    idle(4);

    // starvation: one entry loses LIMIT times, then wins exactly once
    stalls = 0;
    set_in(1, 5, 32'h55, 1, 12, 32'hC0); step();
    set_in(1, 5, 32'h55, 0, 0, 0);
    repeat (6) step();
    chk("starve_stalls", stalls, 1);
    idle(3);

    // x0 results dropped; push and pop in the same cycle keeps count at 1
    set_in(0, 0, 0, 1, 0, 32'hDEAD);  step();
    set_in(0, 0, 0, 1, 13, 32'hD0);   step();
    set_in(0, 0, 0, 1, 14, 32'hD1);   step();
    set_in(0, 0, 0, 1, 17, 32'hD2);   step();
    idle(4);

    // reset with two entries buffered and a write in flight
    set_in(1, 3, 32'h33, 1, 15, 32'hE0); step();
    set_in(1, 3, 32'h34, 1, 16, 32'hE1); step();
    set_in(1, 3, 32'h35, 0, 0, 0);
    rst = 1'b1; step();
    rst = 1'b0;
    idle(6);

    // randomized traffic with occasional resets; stalled pipeline inputs are held
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
        idle(1);
      end else begin
        if (!last_stall) begin
          wb_we   = ($urandom_range(0, 1) == 1);
          wb_rd   = 5'($urandom_range(0, 31));
          wb_data = $urandom;
        end
        mc_valid = ($urandom_range(0, 2) == 0);
        mc_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        mc_data  = $urandom;
        step();
      end
    end

    idle(10);
    chk("leftover_writes", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
